slon_patgen: RTL and testbench

Parametrised pattern generator that produces a divided output clock and a data word for each output-clock period.
- Generalises the fixed divider/counter/ROM source with selectable pattern modes, a writable pattern table, burst length, start/stop control and a status handshake.
- Sits between the system clock domain and an external sink that samples dout on the rising edge of out_clk.

---
 rtl/slon_patgen.sv | 167 ++++++++++++++++
 tb/tb_slon_patgen.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slon_patgen.sv
// Pattern generator: divided out_clk plus one counter/table/LFSR sample per out_clk period.
// Optional even-parity output dout_par is enabled by defining SLON_PATGEN_PARITY_EN.
module slon_patgen #(
  parameter int unsigned DOUT_WIDTH  = 8,
  parameter int unsigned CLK_FACTOR  = 10,
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned BURST_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   start,
  input  logic                   stop,
  input  logic [1:0]             mode,
  input  logic [BURST_WIDTH-1:0] burst_len,
  input  logic                   tbl_we,
  input  logic [ADDR_WIDTH-1:0]  tbl_addr,
  input  logic [DOUT_WIDTH-1:0]  tbl_din,
  output logic                   out_clk,
  output logic [DOUT_WIDTH-1:0]  dout,
`ifdef SLON_PATGEN_PARITY_EN
  output logic                   dout_par,
`endif
  output logic                   dout_valid,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned CNT_WIDTH = (CLK_FACTOR > 2) ? $clog2(CLK_FACTOR) : 1;
  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_HALF = CNT_WIDTH'(CLK_FACTOR / 2 - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CLK_FACTOR - 1);
  localparam logic [15:0]          LFSR_SEED = 16'h0001;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 state;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [ADDR_WIDTH-1:0]  ptr;
  logic [15:0]            lfsr;
  logic [BURST_WIDTH-1:0] bcnt;
  logic [BURST_WIDTH-1:0] blen_q;
  logic [1:0]             mode_q;

  logic [DOUT_WIDTH-1:0]  tbl [DEPTH];

  logic [ADDR_WIDTH-1:0]  ptr_nxt_c;
  logic [15:0]            lfsr_nxt_c;
  logic [BURST_WIDTH-1:0] bcnt_nxt_c;
  logic                   last_c;
  logic [DOUT_WIDTH-1:0]  sample0_c;
  logic [DOUT_WIDTH-1:0]  sample_nxt_c;

  // Pattern table: write port is independent of enable and state.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tbl[tbl_addr] <= tbl_din;
    end
  end

  assign ptr_nxt_c  = ptr + ADDR_WIDTH'(1);
  assign lfsr_nxt_c = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign bcnt_nxt_c = bcnt + BURST_WIDTH'(1);
  assign last_c     = (blen_q != '0) && (bcnt_nxt_c == blen_q);

  // First sample uses the mode being latched; later samples use the latched mode.
  always_comb begin
    sample0_c = '0;
    case (mode)
      2'd1:    sample0_c = tbl[ADDR_WIDTH'(0)];
      2'd2:    sample0_c = LFSR_SEED[DOUT_WIDTH-1:0];
      default: sample0_c = '0;
    endcase
  end

  always_comb begin
    sample_nxt_c = '0;
    case (mode_q)
      2'd1:    sample_nxt_c = tbl[ptr_nxt_c];
      2'd2:    sample_nxt_c = lfsr_nxt_c[DOUT_WIDTH-1:0];
      default: sample_nxt_c = dout + DOUT_WIDTH'(1);
    endcase
  end

  // Control FSM, divider and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= '0;
      lfsr       <= LFSR_SEED;
      bcnt       <= '0;
      blen_q     <= '0;
      mode_q     <= '0;
      out_clk    <= 1'b0;
      dout       <= '0;
`ifdef SLON_PATGEN_PARITY_EN
      dout_par   <= 1'b0;
`endif
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (!enable) begin
      dout_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state      <= RUN;
            busy       <= 1'b1;
            mode_q     <= mode;
            blen_q     <= burst_len;
            cnt        <= '0;
            ptr        <= '0;
            lfsr       <= LFSR_SEED;
            bcnt       <= '0;
            out_clk    <= 1'b0;
            dout       <= sample0_c;
`ifdef SLON_PATGEN_PARITY_EN
            dout_par   <= ^sample0_c;
`endif
            dout_valid <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state   <= IDLE;
            busy    <= 1'b0;
            out_clk <= 1'b0;
            cnt     <= '0;
          end else if (cnt == CNT_LAST) begin
            cnt     <= '0;
            out_clk <= 1'b0;
            if (last_c) begin
              // Final sample has had its full period; dout keeps it.
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              bcnt       <= bcnt_nxt_c;
              ptr        <= ptr_nxt_c;
              lfsr       <= lfsr_nxt_c;
              dout       <= sample_nxt_c;
`ifdef SLON_PATGEN_PARITY_EN
              dout_par   <= ^sample_nxt_c;
`endif
              dout_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
            if (cnt == CNT_HALF) begin
              out_clk <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slon_patgen.sv
// Self-checking bench for slon_patgen: directed scenarios plus randomized runs
// against a time-index reference model (sample k = enabled RUN cycles / CLK_FACTOR).
module tb_slon_patgen;

  localparam int DW    = 8;
  localparam int CF    = 10;
  localparam int AW    = 4;
  localparam int BW    = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          start;
  logic          stop;
  logic [1:0]    mode;
  logic [BW-1:0] burst_len;
  logic          tbl_we;
  logic [AW-1:0] tbl_addr;
  logic [DW-1:0] tbl_din;
  logic          out_clk;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          busy;
  logic          done;
`ifdef SLON_PATGEN_PARITY_EN
  logic          dout_par;
`endif

  slon_patgen #(
    .DOUT_WIDTH (DW),
    .CLK_FACTOR (CF),
    .ADDR_WIDTH (AW),
    .BURST_WIDTH(BW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .burst_len (burst_len),
    .tbl_we    (tbl_we),
    .tbl_addr  (tbl_addr),
    .tbl_din   (tbl_din),
    .out_clk   (out_clk),
    .dout      (dout),
`ifdef SLON_PATGEN_PARITY_EN
    .dout_par  (dout_par),
`endif
    .dout_valid(dout_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Reference model state.
  bit            m_run;
  int            m_t;
  logic [1:0]    m_mode;
  int            m_blen;
  logic [DW-1:0] tbl_m [DEPTH];
  logic [DW-1:0] e_dout;
  bit            e_oc;
  bit            e_valid;
  bit            e_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] sample(input int k);
    logic [15:0] s;
    case (m_mode)
      2'd1: return tbl_m[k % DEPTH];
      2'd2: begin
        s = 16'h0001;
        for (int i = 0; i < k; i++) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        return s[DW-1:0];
      end
      default: return DW'(k);
    endcase
  endfunction

  task automatic model_reset();
    m_run = 0; m_t = 0; m_mode = 2'd0; m_blen = 0;
    e_dout = '0; e_oc = 0; e_valid = 0; e_done = 0;
  endtask

  // One clock: update the model from the inputs seen at the edge, then check on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (!enable) begin
      e_valid = 0; e_done = 0;
    end else begin
      e_valid = 0; e_done = 0;
      if (!m_run) begin
        if (start && !stop) begin
          m_run = 1; m_t = 0; m_mode = mode; m_blen = int'(burst_len);
          e_oc = 0; e_dout = sample(0); e_valid = 1;
        end
      end else if (stop) begin
        m_run = 0; e_oc = 0;
      end else begin
        m_t++;
        if (m_blen != 0 && m_t == m_blen * CF) begin
          m_run = 0; e_done = 1; e_oc = 0;
        end else begin
          e_oc = (m_t % CF) >= CF / 2;
          if (m_t % CF == 0) begin
            e_dout = sample(m_t / CF); e_valid = 1;
          end
        end
      end
    end
    if (tbl_we) tbl_m[tbl_addr] = tbl_din;
    @(negedge clk);
    chk("out_clk", 32'(out_clk), 32'(e_oc));
    chk("dout", 32'(dout), 32'(e_dout));
    chk("dout_valid", 32'(dout_valid), 32'(e_valid));
    chk("busy", 32'(busy), 32'(m_run));
    chk("done", 32'(done), 32'(e_done));
`ifdef SLON_PATGEN_PARITY_EN
    chk("dout_par", 32'(dout_par), 32'(^e_dout));
`endif
  endtask

  task automatic run_until_done(input int budget, output int cyc, output int nval, output int ndone);
    cyc = 0; nval = 0; ndone = 0;
    while (cyc < budget && ndone == 0) begin
      cycle();
      cyc++;
      if (dout_valid) nval++;
      if (done) ndone++;
    end
    if (ndone == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic start_run(input logic [1:0] md, input int blen);
    mode = md; burst_len = BW'(blen); start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  int cyc, nval, ndone, idx;
  int strobes [$];
  logic [DW-1:0] exp3 [8];

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; enable = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0;
    burst_len = '0; tbl_we = 1'b0; tbl_addr = '0; tbl_din = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_out_clk", 32'(out_clk), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (2) cycle();

    // 1: counter burst of 4.
    start_run(2'd0, 4);
    chk("t1_first", 32'(dout), 32'd0);
    run_until_done(100, cyc, nval, ndone);
    chk("t1_latency", 32'(cyc), 32'd40);
    chk("t1_strobes", 32'(nval + 1), 32'd4);
    repeat (3) cycle();
    chk("t1_hold", 32'(dout), 32'd3);
    chk("t1_busy", 32'(busy), 32'd0);

    // 2: table burst of 20 wraps the 16-entry table.
    for (int i = 0; i < DEPTH; i++) begin
      tbl_we = 1'b1; tbl_addr = AW'(i); tbl_din = DW'(8'hA0 + i);
      cycle();
    end
    tbl_we = 1'b0;
    start_run(2'd1, 20);
    chk("t2_first", 32'(dout), 32'hA0);
    run_until_done(400, cyc, nval, ndone);
    chk("t2_last", 32'(dout), 32'hA3);
    ndone = 0;
    repeat (12) begin cycle(); if (done) ndone++; end
    chk("t2_single_done", 32'(ndone), 32'd0);

    // 3: LFSR burst of 4.
    exp3[0] = 8'h01; exp3[1] = 8'h02; exp3[2] = 8'h04; exp3[3] = 8'h08;
    for (int i = 4; i < 8; i++) exp3[i] = '0;
    start_run(2'd2, 4);
    chk("t3_s0", 32'(dout), 32'(exp3[0]));
    idx = 1;
    for (int c = 0; c < 100 && !done && idx < 8; c++) begin
      cycle();
      if (dout_valid) begin
        chk("t3_sample", 32'(dout), 32'(exp3[idx]));
        idx++;
      end
    end
    chk("t3_count", 32'(idx), 32'd4);
    repeat (2) cycle();

    // 4: continuous counter, stop 3 clk after the strobe that presents 1.
    start_run(2'd0, 0);
    cyc = 0;
    while (!(dout_valid && dout == DW'(1)) && cyc < 50) begin cycle(); cyc++; end
    if (cyc >= 50) chk("t4_timeout", 32'd0, 32'd1);
    cycle(); cycle();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_out_clk", 32'(out_clk), 32'd0);
    chk("t4_dout", 32'(dout), 32'd1);
    ndone = 0;
    repeat (5) begin cycle(); if (done) ndone++; end
    chk("t4_no_done", 32'(ndone), 32'd0);
    start_run(2'd0, 0);
    chk("t4_restart", 32'(dout), 32'd0);
    stop = 1'b1; cycle(); stop = 1'b0;

    // 5: freeze 7 clk mid-period.
    strobes.delete();
    start_run(2'd0, 3);
    strobes.push_back(0);
    for (int c = 1; c <= 60 && !done; c++) begin
      enable = !(c > 12 && c <= 19);
      cycle();
      if (dout_valid) strobes.push_back(c);
    end
    enable = 1'b1;
    chk("t5_strobes", 32'(strobes.size()), 32'd3);
    if (strobes.size() >= 3) chk("t5_period", 32'(strobes[2] - strobes[1]), 32'd17);
    chk("t5_last", 32'(dout), 32'd2);
    repeat (2) cycle();

    // 6: asynchronous reset mid-burst, table retained.
    start_run(2'd1, 8);
    repeat (25) cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_out_clk", 32'(out_clk), 32'd0);
    chk("t6_dout", 32'(dout), 32'd0);
    chk("t6_valid", 32'(dout_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    model_reset();
    cycle();
    rst_n = 1'b1;
    cycle();
    start_run(2'd1, 4);
    chk("t6_replay0", 32'(dout), 32'hA0);
    run_until_done(100, cyc, nval, ndone);
    chk("t6_last", 32'(dout), 32'hA3);

    // Randomized runs: mode, burst, enable gaps, stray start/stop, table writes.
    for (int it = 0; it < 40; it++) begin
      start_run(2'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
      for (int c = 0; c < 120; c++) begin
        enable   = ($urandom_range(0, 9) != 0);
        start    = ($urandom_range(0, 49) == 0);
        stop     = ($urandom_range(0, 99) == 0);
        tbl_we   = ($urandom_range(0, 3) == 0);
        tbl_addr = AW'($urandom);
        tbl_din  = DW'($urandom);
        cycle();
      end
      enable = 1'b1; start = 1'b0; tbl_we = 1'b0;
      stop = 1'b1; cycle(); stop = 1'b0;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
